// File: rtl/memory_subsystem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// memory_subsystem_pkg : bank power-state encoding and address-width helper
// Rev 1.0
// ---------------------------------------------------------------------------
package memory_subsystem_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    SLEEP  = 2'd2,
    WAKE   = 2'd3
  } pwr_state_e;

  localparam int unsigned DATA_WIDTH = 32;

  function automatic int unsigned bank_addr_bits(input int unsigned num_words);
    return $clog2(num_words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obi_pkg : OBI request/response structs used on the per-bank ports
// Rev 1.0
// ---------------------------------------------------------------------------
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage
`default_nettype wire

// File: rtl/mem_bank_pwr_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bank_pwr_ctrl : per-bank power FSM, wake counter, grant and rvalid
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_bank_pwr_ctrl
  import memory_subsystem_pkg::*;
#(
  parameter int unsigned WakeCycles = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic       sleep_req_i,
  output logic       gnt_o,
  output logic       rvalid_o,
  output logic       sleep_ack_o,
  output pwr_state_e state_o,
  output logic       clk_en_o,
  output logic       set_retentive_no
);

  localparam int unsigned WAKE_LOAD = (WakeCycles > 1) ? WakeCycles - 1 : 0;
  localparam int unsigned CNT_W     = (WAKE_LOAD > 0) ? $clog2(WAKE_LOAD + 1) : 1;

  pwr_state_e       state_q, state_d;
  logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic             rvalid_q, rvalid_d;

  assign gnt_o = req_i & (state_q == ACTIVE);

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    rvalid_d   = gnt_o;
    case (state_q)
      ACTIVE: if (sleep_req_i) state_d = DRAIN;
      DRAIN: begin
        // Hold off retention until the last granted read has returned.
        if (!sleep_req_i)   state_d = ACTIVE;
        else if (!rvalid_q) state_d = SLEEP;
      end
      SLEEP: begin
        if (!sleep_req_i) begin
          state_d    = WAKE;
          wake_cnt_d = CNT_W'(WAKE_LOAD);
        end
      end
      WAKE: begin
        if (wake_cnt_q == '0) state_d = ACTIVE;
        else                  wake_cnt_d = wake_cnt_q - CNT_W'(1);
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ACTIVE;
      wake_cnt_q <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign rvalid_o         = rvalid_q;
  assign state_o          = state_q;
  assign sleep_ack_o      = (state_q == SLEEP);
  assign clk_en_o         = (state_q != SLEEP);
  assign set_retentive_no = (state_q != SLEEP);

endmodule
`default_nettype wire

// File: rtl/sram_wrapper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_wrapper : single-port SRAM bank model with byte enables, 1-cycle read
// Rev 1.0
// ---------------------------------------------------------------------------
module sram_wrapper #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32
) (
  input  logic                        clk_i,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [DataWidth/8-1:0]      be_i,
  input  logic [$clog2(NumWords)-1:0] addr_i,
  input  logic [DataWidth-1:0]        wdata_i,
  input  logic                        set_retentive_ni,
  output logic [DataWidth-1:0]        rdata_o
);

  logic [DataWidth-1:0] mem [NumWords];
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 access;

  // A bank held in retention ignores any access attempt.
  assign access = req_i & set_retentive_ni;

  always_comb begin
    rdata_d = rdata_q;
    if (access && !we_i) rdata_d = mem[addr_i];
  end

  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
    if (access && we_i) begin
      for (int i = 0; i < DataWidth / 8; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/tc_clk_gating.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tc_clk_gating : latch-based glitch-free clock gate (behavioural cell)
// Rev 1.0
// ---------------------------------------------------------------------------
module tc_clk_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latched;

  // Enable only moves while the clock is low, so clk_o never chops a high phase.
  always_latch begin
    if (!clk_i) en_latched = en_i | test_en_i;
  end

  assign clk_o = clk_i & en_latched;

endmodule
`default_nettype wire

// File: rtl/memory_subsystem_pm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// memory_subsystem_pm : SRAM bank array with per-bank retention handshake
// Rev 1.0
// ---------------------------------------------------------------------------
module memory_subsystem_pm
  import memory_subsystem_pkg::*;
#(
  parameter int unsigned NumBanks   = 12,
  parameter int unsigned NumWords   = 8192,
  parameter int unsigned WakeCycles = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  obi_pkg::obi_req_t  [NumBanks-1:0]   ram_req_i,
  output obi_pkg::obi_resp_t [NumBanks-1:0]   ram_resp_o,
  input  logic               [NumBanks-1:0]   pwr_sleep_req_i,
  output logic               [NumBanks-1:0]   pwr_sleep_ack_o,
  output logic               [2*NumBanks-1:0] pwr_state_o
);

  localparam int unsigned ADDR_BITS = bank_addr_bits(NumWords);

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic       w_gnt;
    logic       w_clk_en;
    logic       w_bank_clk;
    logic       w_retentive_n;
    logic       w_unused_addr;
    pwr_state_e w_state;

    mem_bank_pwr_ctrl #(
      .WakeCycles (WakeCycles)
    ) u_ctrl (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .req_i            (ram_req_i[b].req),
      .sleep_req_i      (pwr_sleep_req_i[b]),
      .gnt_o            (w_gnt),
      .rvalid_o         (ram_resp_o[b].rvalid),
      .sleep_ack_o      (pwr_sleep_ack_o[b]),
      .state_o          (w_state),
      .clk_en_o         (w_clk_en),
      .set_retentive_no (w_retentive_n)
    );

    tc_clk_gating u_cg (
      .clk_i     (clk_i),
      .en_i      (w_clk_en),
      .test_en_i (1'b0),
      .clk_o     (w_bank_clk)
    );

    // Word-addressed bank: byte offset and bits above the bank size are dropped.
    sram_wrapper #(
      .NumWords  (NumWords),
      .DataWidth (DATA_WIDTH)
    ) u_sram (
      .clk_i            (w_bank_clk),
      .req_i            (w_gnt),
      .we_i             (ram_req_i[b].we),
      .be_i             (ram_req_i[b].be),
      .addr_i           (ram_req_i[b].addr[ADDR_BITS+1:2]),
      .wdata_i          (ram_req_i[b].wdata),
      .set_retentive_ni (w_retentive_n),
      .rdata_o          (ram_resp_o[b].rdata)
    );

    assign w_unused_addr          = ^{ram_req_i[b].addr[31:ADDR_BITS+2], ram_req_i[b].addr[1:0]};
    assign ram_resp_o[b].gnt      = w_gnt;
    assign pwr_state_o[2*b +: 2]  = w_state;
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_subsystem_pm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_memory_subsystem_pm : directed scenarios plus randomized traffic vs model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_memory_subsystem_pm;
  import obi_pkg::*;

  localparam int NB    = 12;
  localparam int NW    = 8192;
  localparam int WC    = 4;
  localparam int S_ACT = 0;
  localparam int S_DRN = 1;
  localparam int S_SLP = 2;
  localparam int S_WAK = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  obi_req_t  [NB-1:0]  ram_req;
  obi_resp_t [NB-1:0]  ram_resp;
  logic      [NB-1:0]  sleep_req;
  logic      [NB-1:0]  sleep_ack;
  logic      [2*NB-1:0] pwr_state;

  int errors = 0;
  int checks = 0;

  // Reference model: per-bank mode, remaining wake cycles, outstanding response, memory contents.
  int          m_state     [NB];
  int          m_wake_left [NB];
  bit          m_rv        [NB];
  bit          m_rdk       [NB];
  logic [31:0] m_rdata     [NB];
  logic [31:0] m_mem       [int];

  int bank0_clk_edges = 0;

  memory_subsystem_pm #(
    .NumBanks   (NB),
    .NumWords   (NW),
    .WakeCycles (WC)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .ram_req_i       (ram_req),
    .ram_resp_o      (ram_resp),
    .pwr_sleep_req_i (sleep_req),
    .pwr_sleep_ack_o (sleep_ack),
    .pwr_state_o     (pwr_state)
  );

  always #5 clk = ~clk;
  always @(posedge dut.g_bank[0].w_bank_clk) bank0_clk_edges++;

  function automatic logic [1:0] st(input int b);
    return pwr_state[2*b +: 2];
  endfunction

  function automatic bit exp_gnt(input int b);
    return ram_req[b].req && (m_state[b] == S_ACT);
  endfunction

  task automatic drive(input int b, input bit req, input bit we, input int word,
                       input logic [31:0] wdata, input logic [3:0] be);
    ram_req[b].req   = req;
    ram_req[b].we    = we;
    ram_req[b].be    = be;
    ram_req[b].addr  = 32'(word) << 2;
    ram_req[b].wdata = wdata;
  endtask

  // Advance one clock edge and update the model; returns 1 time unit after the edge.
  task automatic tick();
    bit g [NB];
    for (int b = 0; b < NB; b++) g[b] = exp_gnt(b);
    @(posedge clk);
    for (int b = 0; b < NB; b++) begin
      int key;
      key = b * NW + (int'(ram_req[b].addr[31:2]) % NW);
      if (!rst_n) begin
        m_state[b] = S_ACT; m_wake_left[b] = 0; m_rv[b] = 0; m_rdk[b] = 0;
      end else begin
        case (m_state[b])
          S_ACT: if (sleep_req[b]) m_state[b] = S_DRN;
          S_DRN: begin
            if (!sleep_req[b]) m_state[b] = S_ACT;
            else if (!m_rv[b]) m_state[b] = S_SLP;
          end
          S_SLP: begin
            if (!sleep_req[b]) begin
              m_state[b] = S_WAK;
              m_wake_left[b] = (WC < 1) ? 1 : WC;
            end
          end
          default: begin
            m_wake_left[b]--;
            if (m_wake_left[b] == 0) m_state[b] = S_ACT;
          end
        endcase
        m_rv[b] = g[b];
      end
      if (g[b]) begin
        if (ram_req[b].we) begin
          m_rdk[b] = 0;
          if (m_mem.exists(key)) begin
            logic [31:0] w;
            w = m_mem[key];
            for (int i = 0; i < 4; i++)
              if (ram_req[b].be[i]) w[8*i +: 8] = ram_req[b].wdata[8*i +: 8];
            m_mem[key] = w;
          end else if (ram_req[b].be == 4'hF) begin
            m_mem[key] = ram_req[b].wdata;
          end
        end else begin
          m_rdk[b] = m_mem.exists(key);
          if (m_rdk[b]) m_rdata[b] = m_mem[key];
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (st(b) !== 2'(S_ACT) || sleep_ack[b] !== 1'b0 || ram_resp[b].rvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset bank%0d: state=%0d ack=%b rvalid=%b, expected state=0 ack=0 rvalid=0",
                 b, st(b), sleep_ack[b], ram_resp[b].rvalid);
      end
    end
    checks++;
    if (dut.g_bank[0].u_ctrl.set_retentive_no !== 1'b1 || dut.g_bank[0].u_ctrl.clk_en_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_power bank0: retentive_n=%b clk_en=%b, expected 1 1",
               dut.g_bank[0].u_ctrl.set_retentive_no, dut.g_bank[0].u_ctrl.clk_en_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_write();
    drive(3, 1, 1, 'h1FF, 32'hDEADBEEF, 4'hF);
    #1;
    checks++;
    if (ram_resp[3].gnt !== 1'b1) begin
      errors++; $display("FAIL rw_write_gnt: gnt=%b expected 1", ram_resp[3].gnt);
    end
    tick();
    checks++;
    if (ram_resp[3].rvalid !== 1'b1) begin
      errors++; $display("FAIL rw_write_rvalid: rvalid=%b expected 1", ram_resp[3].rvalid);
    end
    drive(3, 1, 0, 'h1FF, 32'h0, 4'h0);
    #1;
    checks++;
    if (ram_resp[3].gnt !== 1'b1) begin
      errors++; $display("FAIL rw_read_gnt: gnt=%b expected 1", ram_resp[3].gnt);
    end
    tick();
    checks++;
    if (ram_resp[3].rvalid !== 1'b1 || ram_resp[3].rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rw_read_data: rvalid=%b rdata=%h expected 1 deadbeef", ram_resp[3].rvalid, ram_resp[3].rdata);
    end
    drive(3, 1, 1, 'h1FF, 32'h0000AA00, 4'b0010);
    tick();
    drive(3, 1, 0, 'h1FF, 32'h0, 4'h0);
    tick();
    checks++;
    if (ram_resp[3].rdata !== 32'hDEADAAEF) begin
      errors++; $display("FAIL rw_byte_enable: rdata=%h expected deadaaef", ram_resp[3].rdata);
    end
    drive(3, 0, 0, 0, 32'h0, 4'h0);
    tick();
    checks++;
    if (ram_resp[3].rvalid !== 1'b0) begin
      errors++; $display("FAIL rw_idle_rvalid: rvalid=%b expected 0", ram_resp[3].rvalid);
    end
  endtask

  task automatic test_sleep_data();
    logic [31:0] v;
    int          e0;
    v = $urandom;
    drive(0, 1, 1, 5, v, 4'hF);
    tick();
    drive(0, 0, 0, 0, 32'h0, 4'h0);
    sleep_req[0] = 1'b1;
    tick();
    checks++;
    if (st(0) !== 2'(S_DRN) || sleep_ack[0] !== 1'b0) begin
      errors++; $display("FAIL sleep_drain: state=%0d ack=%b expected 1 0", st(0), sleep_ack[0]);
    end
    tick();
    checks++;
    if (st(0) !== 2'(S_SLP) || sleep_ack[0] !== 1'b1 || dut.g_bank[0].u_ctrl.set_retentive_no !== 1'b0
        || dut.g_bank[0].u_ctrl.clk_en_o !== 1'b0) begin
      errors++;
      $display("FAIL sleep_enter: state=%0d ack=%b retentive_n=%b clk_en=%b expected 2 1 0 0", st(0),
               sleep_ack[0], dut.g_bank[0].u_ctrl.set_retentive_no, dut.g_bank[0].u_ctrl.clk_en_o);
    end
    e0 = bank0_clk_edges;
    drive(0, 1, 0, 5, 32'h0, 4'h0);
    #1;
    checks++;
    if (ram_resp[0].gnt !== 1'b0) begin
      errors++; $display("FAIL sleep_gnt: gnt=%b expected 0", ram_resp[0].gnt);
    end
    tick();
    tick();
    sleep_req[0] = 1'b0;
    tick();
    checks++;
    if (bank0_clk_edges !== e0) begin
      errors++; $display("FAIL sleep_clock_gated: bank clock edges=%0d expected 0", bank0_clk_edges - e0);
    end
    checks++;
    if (dut.g_bank[0].u_ctrl.set_retentive_no !== 1'b1 || dut.g_bank[0].u_ctrl.clk_en_o !== 1'b1) begin
      errors++;
      $display("FAIL wake_power: retentive_n=%b clk_en=%b expected 1 1",
               dut.g_bank[0].u_ctrl.set_retentive_no, dut.g_bank[0].u_ctrl.clk_en_o);
    end
    for (int i = 0; i < WC; i++) begin
      checks++;
      if (st(0) !== 2'(S_WAK) || ram_resp[0].gnt !== 1'b0) begin
        errors++; $display("FAIL wake_cycle%0d: state=%0d gnt=%b expected 3 0", i, st(0), ram_resp[0].gnt);
      end
      tick();
    end
    checks++;
    if (st(0) !== 2'(S_ACT) || ram_resp[0].gnt !== 1'b1) begin
      errors++; $display("FAIL wake_done: state=%0d gnt=%b expected 0 1", st(0), ram_resp[0].gnt);
    end
    tick();
    checks++;
    if (ram_resp[0].rvalid !== 1'b1 || ram_resp[0].rdata !== v) begin
      errors++;
      $display("FAIL sleep_retained: rvalid=%b rdata=%h expected 1 %h", ram_resp[0].rvalid, ram_resp[0].rdata, v);
    end
    drive(0, 0, 0, 0, 32'h0, 4'h0);
    tick();
  endtask

  task automatic test_drain_inflight();
    logic [31:0] v;
    v = $urandom;
    drive(5, 1, 1, 9, v, 4'hF);
    tick();
    drive(5, 1, 0, 9, 32'h0, 4'h0);
    sleep_req[5] = 1'b1;
    #1;
    checks++;
    if (ram_resp[5].gnt !== 1'b1) begin
      errors++; $display("FAIL drain_same_cycle_gnt: gnt=%b expected 1", ram_resp[5].gnt);
    end
    tick();
    drive(5, 0, 0, 0, 32'h0, 4'h0);
    checks++;
    if (st(5) !== 2'(S_DRN) || ram_resp[5].rvalid !== 1'b1 || ram_resp[5].rdata !== v) begin
      errors++;
      $display("FAIL drain_rvalid: state=%0d rvalid=%b rdata=%h expected 1 1 %h",
               st(5), ram_resp[5].rvalid, ram_resp[5].rdata, v);
    end
    tick();
    checks++;
    if (st(5) !== 2'(S_DRN) || ram_resp[5].rvalid !== 1'b0) begin
      errors++; $display("FAIL drain_hold: state=%0d rvalid=%b expected 1 0", st(5), ram_resp[5].rvalid);
    end
    tick();
    checks++;
    if (st(5) !== 2'(S_SLP) || sleep_ack[5] !== 1'b1) begin
      errors++; $display("FAIL drain_to_sleep: state=%0d ack=%b expected 2 1", st(5), sleep_ack[5]);
    end
    sleep_req[5] = 1'b0;
    repeat (WC + 1) tick();
    checks++;
    if (st(5) !== 2'(S_ACT)) begin
      errors++; $display("FAIL drain_wake_active: state=%0d expected 0", st(5));
    end
  endtask

  task automatic test_resleep_wake();
    sleep_req[7] = 1'b1;
    tick();
    tick();
    sleep_req[7] = 1'b0;
    tick();
    tick();
    sleep_req[7] = 1'b1;
    tick();
    tick();
    checks++;
    if (st(7) !== 2'(S_WAK)) begin
      errors++; $display("FAIL resleep_no_abort: state=%0d expected 3", st(7));
    end
    tick();
    checks++;
    if (st(7) !== 2'(S_ACT)) begin
      errors++; $display("FAIL resleep_active: state=%0d expected 0", st(7));
    end
    tick();
    checks++;
    if (st(7) !== 2'(S_DRN)) begin
      errors++; $display("FAIL resleep_drain: state=%0d expected 1", st(7));
    end
    tick();
    checks++;
    if (st(7) !== 2'(S_SLP)) begin
      errors++; $display("FAIL resleep_sleep: state=%0d expected 2", st(7));
    end
    sleep_req[7] = 1'b0;
    repeat (WC + 1) tick();
  endtask

  task automatic test_reset_sleep();
    sleep_req[2] = 1'b1;
    tick();
    tick();
    checks++;
    if (st(2) !== 2'(S_SLP)) begin
      errors++; $display("FAIL rst_sleep_setup: state=%0d expected 2", st(2));
    end
    sleep_req[2] = 1'b0;
    drive(4, 1, 0, 0, 32'h0, 4'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(4, 0, 0, 0, 32'h0, 4'h0);
    checks++;
    if (st(2) !== 2'(S_ACT) || sleep_ack[2] !== 1'b0 || dut.g_bank[2].u_ctrl.set_retentive_no !== 1'b1
        || ram_resp[2].rvalid !== 1'b0 || ram_resp[4].rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_sleep: state=%0d ack=%b retentive_n=%b rvalid2=%b rvalid4=%b expected 0 0 1 0 0",
               st(2), sleep_ack[2], dut.g_bank[2].u_ctrl.set_retentive_no, ram_resp[2].rvalid, ram_resp[4].rvalid);
    end
    tick();
  endtask

  task automatic test_independence();
    int grants;
    grants = 0;
    sleep_req[1] = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(2, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, 4'hF);
      drive(1, 1, 0, 0, 32'h0, 4'h0);
      #1;
      checks++;
      if (ram_resp[1].gnt !== 1'b0) begin
        errors++; $display("FAIL indep_sleep_gnt cycle%0d: gnt=%b expected 0", i, ram_resp[1].gnt);
      end
      if (ram_resp[2].gnt === 1'b1) grants++;
      tick();
      checks++;
      if (ram_resp[2].rvalid !== 1'b1) begin
        errors++; $display("FAIL indep_rvalid cycle%0d: rvalid=%b expected 1", i, ram_resp[2].rvalid);
      end
      if (m_rdk[2]) begin
        checks++;
        if (ram_resp[2].rdata !== m_rdata[2]) begin
          errors++; $display("FAIL indep_rdata cycle%0d: rdata=%h expected %h", i, ram_resp[2].rdata, m_rdata[2]);
        end
      end
    end
    checks++;
    if (grants !== 16) begin
      errors++; $display("FAIL indep_throughput: grants=%0d expected 16", grants);
    end
    drive(1, 0, 0, 0, 32'h0, 4'h0);
    drive(2, 0, 0, 0, 32'h0, 4'h0);
    sleep_req[1] = 1'b0;
    repeat (WC + 1) tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 15) == 0) sleep_req[b] = ~sleep_req[b];
        drive(b, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
      end
      #1;
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (ram_resp[b].gnt !== exp_gnt(b)) begin
          errors++; $display("FAIL rand_gnt cyc%0d bank%0d: gnt=%b expected %b", cyc, b, ram_resp[b].gnt, exp_gnt(b));
        end
      end
      tick();
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (st(b) !== 2'(m_state[b]) || sleep_ack[b] !== (m_state[b] == S_SLP) || ram_resp[b].rvalid !== m_rv[b]) begin
          errors++;
          $display("FAIL rand_ctrl cyc%0d bank%0d: state=%0d ack=%b rvalid=%b expected %0d %b %b", cyc, b,
                   st(b), sleep_ack[b], ram_resp[b].rvalid, m_state[b], m_state[b] == S_SLP, m_rv[b]);
        end
        if (m_rv[b] && m_rdk[b]) begin
          checks++;
          if (ram_resp[b].rdata !== m_rdata[b]) begin
            errors++;
            $display("FAIL rand_rdata cyc%0d bank%0d: rdata=%h expected %h", cyc, b, ram_resp[b].rdata, m_rdata[b]);
          end
        end
      end
    end
    sleep_req = '0;
    ram_req   = '0;
    repeat (WC + 3) tick();
  endtask

  initial begin
    ram_req   = '0;
    sleep_req = '0;
    rst_n     = 1'b0;
    #1;
    test_reset();
    test_read_write();
    test_sleep_data();
    test_drain_inflight();
    test_resleep_wake();
    test_reset_sleep();
    test_independence();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
